// File: rtl/traffic_timer.sv
// traffic_timer: seconds-base timer for the highway / farm-way light controllers.
//
// Divides clk down to a one-second tick, counts elapsed whole seconds since
// the last clear (saturating at LONG_SEC) and raises sticky short/long
// timeout levels that the controllers use as their timeout inputs.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   timer_clr     in   synchronous clear, restarts timing (beats the tick)
//   pause         in   only with TRAFFIC_TIMER_PAUSE_EN: freezes counting in RUN
//   short_timeout out  high once SHORT_SEC seconds have elapsed
//   long_timeout  out  high once LONG_SEC seconds have elapsed
//   sec_count     out  elapsed whole seconds, saturating at LONG_SEC
//   running       out  high while in RUN
//
// Optional feature macro: TRAFFIC_TIMER_PAUSE_EN (adds the pause input).
module traffic_timer #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned SHORT_SEC = 3,
    parameter int unsigned LONG_SEC  = 15,
    parameter int unsigned SEC_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_clr,
`ifdef TRAFFIC_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             short_timeout,
    output logic             long_timeout,
    output logic [SEC_W-1:0] sec_count,
    output logic             running
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0] SHORT_V  = SEC_W'(SHORT_SEC);
    localparam logic [SEC_W-1:0] LONG_V   = SEC_W'(LONG_SEC);

    // Elaboration-time parameter legality check
    if ((TICK_DIV < 1) || (SHORT_SEC < 1) || (SHORT_SEC >= LONG_SEC) ||
        (longint'(LONG_SEC) > ((longint'(1) << SEC_W) - 1))) begin : g_bad_params
        $error("traffic_timer: illegal parameter combination");
    end

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_EXPIRED = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PRE_W-1:0]   prescaler;
    logic [PRE_W-1:0]   prescaler_d;
    logic [SEC_W-1:0]   sec_count_d;
    logic               short_d;
    logic               long_d;
    logic               running_d;
    logic               tick_c;
    logic               freeze_c;
    logic [SEC_W-1:0]   sec_inc_c;

    // Counting freeze request (only exists with the pause feature)
`ifdef TRAFFIC_TIMER_PAUSE_EN
    assign freeze_c = pause;
`else
    assign freeze_c = 1'b0;
`endif

    assign tick_c    = (prescaler == PRE_LAST);
    assign sec_inc_c = sec_count + SEC_W'(1);

    // Next-state and next-output logic; timeouts are computed from the
    // incremented count so they land on the same edge as sec_count.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler;
        sec_count_d = sec_count;
        short_d     = short_timeout;
        long_d      = long_timeout;

        if (timer_clr) begin
            state_d     = ST_RUN;
            prescaler_d = '0;
            sec_count_d = '0;
            short_d     = 1'b0;
            long_d      = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!freeze_c) begin
                        if (tick_c) begin
                            prescaler_d = '0;
                            sec_count_d = sec_inc_c;
                            if (sec_inc_c >= SHORT_V) begin
                                short_d = 1'b1;
                            end
                            if (sec_inc_c == LONG_V) begin
                                long_d  = 1'b1;
                                state_d = ST_EXPIRED;
                            end
                        end else begin
                            prescaler_d = prescaler + PRE_W'(1);
                        end
                    end
                end
                ST_EXPIRED: begin
                    prescaler_d = '0;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            prescaler     <= '0;
            sec_count     <= '0;
            short_timeout <= 1'b0;
            long_timeout  <= 1'b0;
            running       <= 1'b1;
        end else begin
            state_q       <= state_d;
            prescaler     <= prescaler_d;
            sec_count     <= sec_count_d;
            short_timeout <= short_d;
            long_timeout  <= long_d;
            running       <= running_d;
        end
    end

endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: randomized scoreboard bench for traffic_timer.
// Reference model: elapsed counting edges since the last clear/reset;
// seconds = min(elapsed / TICK_DIV, LONG_SEC), timeouts are thresholds on it.
module tb_traffic_timer;

    localparam int unsigned TD = 4;
    localparam int unsigned SH = 2;
    localparam int unsigned LG = 5;
    localparam int unsigned SW = 8;
    localparam int unsigned N_CYC = 400;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          timer_clr = 1'b0;
`ifdef TRAFFIC_TIMER_PAUSE_EN
    logic          pause = 1'b0;
`endif
    logic          short_timeout;
    logic          long_timeout;
    logic [SW-1:0] sec_count;
    logic          running;

    traffic_timer #(
        .TICK_DIV (TD),
        .SHORT_SEC(SH),
        .LONG_SEC (LG),
        .SEC_W    (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .timer_clr    (timer_clr),
`ifdef TRAFFIC_TIMER_PAUSE_EN
        .pause        (pause),
`endif
        .short_timeout(short_timeout),
        .long_timeout (long_timeout),
        .sec_count    (sec_count),
        .running      (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sec;
        int unsigned sh;
        int unsigned lg;
        int unsigned run;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned elapsed = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model_out(input int unsigned el, input int unsigned cyc);
        exp_t e;
        int unsigned s;
        s = el / TD;
        if (s > LG) s = LG;
        e.sec = s;
        e.sh  = (s >= SH) ? 1 : 0;
        e.lg  = (s >= LG) ? 1 : 0;
        e.run = (s < LG) ? 1 : 0;
        e.cyc = cyc;
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_sec"},     int'(sec_count), 0);
        chk({tag, "_short"},   int'(short_timeout), 0);
        chk({tag, "_long"},    int'(long_timeout), 0);
        chk({tag, "_running"}, int'(running), 1);
    endtask

    // Monitor: after each active edge, pop the expected outputs and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("sec_count[c%0d]", e.cyc), int'(sec_count), e.sec);
                chk($sformatf("short[c%0d]", e.cyc), int'(short_timeout), e.sh);
                chk($sformatf("long[c%0d]", e.cyc), int'(long_timeout), e.lg);
                chk($sformatf("running[c%0d]", e.cyc), int'(running), e.run);
            end
        end
    end

    // Stimulus: drive at negedge, push the expectation for the next posedge
    initial begin
        logic clr;
        logic pz;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset   = 1'b1;
        elapsed = 0;

        for (int n = 0; n < int'(N_CYC); n++) begin
            if (n == 150 || n == 300) begin
                // Asynchronous reset in the middle of a clock period
                #2 reset = 1'b0;
                #1 check_reset_values($sformatf("async_reset_c%0d", n));
                @(negedge clk);
                reset   = 1'b1;
                elapsed = 0;
            end

            clr = (n == 45) || (n == 58) || (n >= 70 && n <= 72) ||
                  (n == 79) || (n >= 100 && $urandom_range(0, 11) == 0);
            pz = 1'b0;
`ifdef TRAFFIC_TIMER_PAUSE_EN
            pz = (n >= 200) && ($urandom_range(0, 3) == 0);
            pause = pz;
`endif
            timer_clr = clr;

            if (clr) begin
                elapsed = 0;
            end else if (!(pz && elapsed < LG * TD)) begin
                if (elapsed < LG * TD) elapsed++;
            end
            sb.push_back(model_out(elapsed, n));

            @(negedge clk);
        end

        timer_clr = 1'b0;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Seconds-base timer that feeds the highway and farm-way light controllers.
- Divides clk down to a one-second tick and counts elapsed seconds since the last clear.
- Raises short_timeout and long_timeout levels, which the controllers consume as their timeout inputs.
- timer_clr is driven by the controllers' timer-reset outputs (timer_hw_reset OR'd with the farm-way equivalent at top level).

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick; legal range >= 1.
- SHORT_SEC, 3, seconds to short_timeout; legal range 1 .. LONG_SEC-1.
- LONG_SEC, 15, seconds to long_timeout; legal range > SHORT_SEC.
- SEC_W, 8, width of the seconds counter; 2^SEC_W-1 must be >= LONG_SEC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- timer_clr  input  1  synchronous clear; restarts timing.
- short_timeout  output  1  level, high once SHORT_SEC seconds have elapsed since the last clear/reset.
- long_timeout  output  1  level, high once LONG_SEC seconds have elapsed since the last clear/reset.
- sec_count  output  SEC_W  elapsed whole seconds, saturating at LONG_SEC.
- running  output  1  high while in RUN state.

Behaviour:
- Reset: reset low asynchronously forces the following; the block starts counting on the first clk edge after reset deasserts.
  - prescaler = 0, sec_count = 0, short_timeout = 0, long_timeout = 0.
  - State = RUN, running = 1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler == TICK_DIV-1). With TICK_DIV = 1, tick is high every cycle.
- FSM, two states, RUN and EXPIRED:
  - RUN: on tick, sec_count increments. If the incremented value equals LONG_SEC, go to EXPIRED.
  - EXPIRED: prescaler is held at 0; sec_count holds LONG_SEC; running = 0.
  - Any state: timer_clr = 1 at an edge forces prescaler = 0, sec_count = 0, both timeouts = 0, state = RUN.
- Priority: timer_clr beats tick in the same cycle. The tick is discarded and the count restarts from 0.
- Output timing:
  - short_timeout and long_timeout are registered. Each is set on the same edge that sec_count takes a value >= SHORT_SEC or >= LONG_SEC respectively, so there is no extra cycle of latency relative to sec_count.
  - Both are cleared only by timer_clr or reset; they do not self-clear.
  - long_timeout = 1 implies short_timeout = 1.
- Clear timing: timer_clr held high for N cycles keeps the counter at 0 for all N cycles. Counting resumes at the first edge with timer_clr low, and that edge advances the prescaler to 1.
- Saturation: sec_count never exceeds LONG_SEC and never wraps.
- Widths: prescaler width = $clog2(TICK_DIV), minimum 1.
- Parameter checks: an illegal combination is flagged by an elaboration-time check (simulation $error); not synthesizable logic.

Optional Feature:
- Macro TRAFFIC_TIMER_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - pause = 1 freezes the prescaler and sec_count in RUN; outputs hold.
  - timer_clr still takes effect while paused.
  - pause has no effect in EXPIRED.
- When undefined: no pause port; counting is unconditional in RUN.

Test Plan:
All scenarios use TICK_DIV=4, SHORT_SEC=2, LONG_SEC=5 unless stated; edge k = k-th rising edge after reset deasserts.
1. Free run from reset:
   - sec_count = 1 after edge 4.
   - short_timeout = 1 after edge 8, sec_count = 2.
   - long_timeout = 1 and running = 0 after edge 20, sec_count = 5.
   - Edges 21..40: everything holds.
2. Clear mid-count: pulse timer_clr at edge 10 (sec_count = 2, short = 1).
   - After edge 10: sec_count = 0, short = 0.
   - short re-asserts after edge 18.
3. Clear coincident with tick: timer_clr high at edge 4.
   - sec_count stays 0; first increment occurs at edge 8.
4. Clear from EXPIRED: timer_clr at edge 25.
   - running = 1, both timeouts = 0.
   - long_timeout re-asserts after edge 45.
5. Async reset mid-run: reset low between edges 12 and 13.
   - Outputs go to reset values immediately, without waiting for a clk edge.
   - After release, the scenario 1 timeline repeats.
6. TICK_DIV=1, with TRAFFIC_TIMER_PAUSE_EN defined:
   - short = 1 after edge 2.
   - pause high over edges 3..6: sec_count holds at 2.
   - long = 1 after edge 9.
